// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: branch-condition encodings and fetch-stage defaults.
package mips_pkg;

  localparam int          DEF_WIDTH      = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_3000;
  localparam int          DEF_IMEM_BYTES = 4096;

  typedef enum logic [2:0] {
    COND_EQ  = 3'd0,
    COND_NE  = 3'd1,
    COND_LEZ = 3'd2,
    COND_GTZ = 3'd3,
    COND_LTZ = 3'd4,
    COND_GEZ = 3'd5
  } cond_e;

endpackage

// File: rtl/br_cond.sv
// Six-way branch condition evaluator; shared with the ID-stage bypass checker.
module br_cond
  import mips_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [2:0]       cond,
  output logic             taken
);

  logic w_rs_neg;
  logic w_rs_zero;
  logic w_eq;

  assign w_rs_neg  = rs[WIDTH-1];
  assign w_rs_zero = (rs == '0);
  assign w_eq      = (rs == rt);

  // Reserved encodings (6, 7) fall through to never-taken.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ:  taken = w_eq;
      COND_NE:  taken = ~w_eq;
      COND_LEZ: taken = w_rs_neg | w_rs_zero;
      COND_GTZ: taken = ~w_rs_neg & ~w_rs_zero;
      COND_LTZ: taken = w_rs_neg;
      COND_GEZ: taken = ~w_rs_neg;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: PC register, redirect/exception priority mux,
// delay-slot flag and fetch address-error detection.
module pc_gen
  import mips_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
  parameter logic [WIDTH-1:0] IMEM_BASE  = WIDTH'(DEF_IMEM_BASE),
  parameter int               IMEM_BYTES = DEF_IMEM_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic             id_br,
  input  logic [2:0]       id_cond,
  input  logic             id_j,
  input  logic             id_jr,
  input  logic [15:0]      id_imm16,
  input  logic [25:0]      id_idx26,
  input  logic [WIDTH-1:0] id_rs,
  input  logic [WIDTH-1:0] id_rt,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_4,
  output logic             if_bd,
  output logic             if_adel
);

  // One extra bit so a window ending exactly at 2^WIDTH does not wrap to zero.
  localparam logic [WIDTH:0] IMEM_LIMIT = (WIDTH+1)'(IMEM_BASE) + (WIDTH+1)'(IMEM_BYTES);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_id_pc4;
  logic [WIDTH-1:0] w_br_off;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_j_tgt;
  logic [WIDTH-1:0] w_cti_tgt;
  logic             w_cond_true;
  logic             w_cti_taken;
  logic             w_is_cti;

  br_cond #(
    .WIDTH (WIDTH)
  ) u_br_cond (
    .rs    (id_rs),
    .rt    (id_rt),
    .cond  (id_cond),
    .taken (w_cond_true)
  );

  assign w_pc_plus4 = r_pc + WIDTH'(4);
  assign w_id_pc4   = id_pc + WIDTH'(4);
  assign w_br_off   = {{(WIDTH-18){id_imm16[15]}}, id_imm16, 2'b00};
  assign w_br_tgt   = w_id_pc4 + w_br_off;
  assign w_j_tgt    = {w_id_pc4[WIDTH-1:28], id_idx26, 2'b00};

  assign w_is_cti    = id_br | id_j | id_jr;
  assign w_cti_taken = id_valid & (id_j | id_jr | (id_br & w_cond_true));

  // Fixed jr > j > br order keeps the mux deterministic on malformed decodes.
  always_comb begin
    w_cti_tgt = w_br_tgt;
    if (id_jr)
      w_cti_tgt = id_rs;
    else if (id_j)
      w_cti_tgt = w_j_tgt;
  end

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (exc_req)
      w_pc_next = EXC_VECTOR;
    else if (eret_req)
      w_pc_next = epc;
    else if (stall)
      w_pc_next = r_pc;
    else if (w_cti_taken)
      w_pc_next = w_cti_tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pc <= RESET_PC;
    else
      r_pc <= w_pc_next;
  end

  assign pc        = r_pc;
  assign pc_plus_4 = w_pc_plus4;
  assign if_bd     = rst_n & id_valid & w_is_cti & ~exc_req & ~eret_req;
  assign if_adel   = (r_pc[1:0] != 2'b00) | (r_pc < IMEM_BASE) | ({1'b0, r_pc} >= IMEM_LIMIT);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// against an arithmetic next-PC reference model.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_br;
  logic [2:0]  id_cond;
  logic        id_j;
  logic        id_jr;
  logic [15:0] id_imm16;
  logic [25:0] id_idx26;
  logic [31:0] id_rs;
  logic [31:0] id_rt;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        if_bd;
  logic        if_adel;

  int total = 0;
  int bad   = 0;

  pc_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_br     (id_br),
    .id_cond   (id_cond),
    .id_j      (id_j),
    .id_jr     (id_jr),
    .id_imm16  (id_imm16),
    .id_idx26  (id_idx26),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .pc        (pc),
    .pc_plus_4 (pc_plus_4),
    .if_bd     (if_bd),
    .if_adel   (if_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit ref_cond(input int c, input int rs, input int rt);
    case (c)
      0: return rs == rt;
      1: return rs != rt;
      2: return rs <= 0;
      3: return rs > 0;
      4: return rs < 0;
      5: return rs >= 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit [31:0] ref_next(input bit [31:0] cur);
    bit [31:0] seq4;
    int        off;
    seq4 = id_pc + 32'd4;
    off  = int'($signed(id_imm16)) * 4;
    if (exc_req)  return 32'h0000_4180;
    if (eret_req) return epc;
    if (stall)    return cur;
    if (id_valid && id_jr) return id_rs;
    if (id_valid && id_j)  return (seq4 & 32'hF000_0000) | (32'(id_idx26) * 4);
    if (id_valid && id_br && ref_cond(int'(id_cond), int'(id_rs), int'(id_rt)))
      return seq4 + 32'(off);
    return cur + 32'd4;
  endfunction

  function automatic bit ref_adel(input bit [31:0] a);
    longint u;
    u = longint'(a);
    return (u % 4 != 0) || (u < 64'h3000) || (u >= 64'h3000 + 4096);
  endfunction

  function automatic bit ref_bd();
    return id_valid && (id_br || id_j || id_jr) && !exc_req && !eret_req;
  endfunction

  // ---------------- helpers (stimulus only) ----------------
  task automatic clear_inputs();
    stall = 0; id_valid = 0; id_pc = 0; id_br = 0; id_cond = 0; id_j = 0; id_jr = 0;
    id_imm16 = 0; id_idx26 = 0; id_rs = 0; id_rt = 0; exc_req = 0; eret_req = 0; epc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #23;
    total++;
    if (pc !== 32'h3000) begin $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); bad++; end
    total++;
    if (pc_plus_4 !== 32'h3004) begin $display("FAIL reset_pc4 got=%h exp=%h", pc_plus_4, 32'h3004); bad++; end
    @(negedge clk);
    rst_n = 1;
    tick();
    total++;
    if (pc !== 32'h3004) begin $display("FAIL seq1 got=%h exp=%h", pc, 32'h3004); bad++; end
    tick();
    total++;
    if (pc !== 32'h3008) begin $display("FAIL seq2 got=%h exp=%h", pc, 32'h3008); bad++; end
    total++;
    if (if_adel !== 1'b0) begin $display("FAIL seq_adel got=%b exp=0", if_adel); bad++; end
    $display("test_reset: pc=%h", pc);
  endtask

  task automatic test_beq();
    id_valid = 1; id_pc = 32'h3010; id_br = 1; id_cond = 3'd0;
    id_rs = 5; id_rt = 5; id_imm16 = 16'hFFFC;
    #1;
    total++;
    if (if_bd !== 1'b1) begin $display("FAIL beq_bd got=%b exp=1", if_bd); bad++; end
    tick();
    total++;
    if (pc !== 32'h3004) begin $display("FAIL beq_target got=%h exp=%h", pc, 32'h3004); bad++; end
    clear_inputs();
    $display("test_beq: pc=%h", pc);
  endtask

  task automatic test_gtz_stall_j();
    id_valid = 1; id_pc = 32'h3000; id_br = 1; id_cond = 3'd3; id_rs = 32'h8000_0000;
    tick();
    total++;
    if (pc !== 32'h3008) begin $display("FAIL gtz_untaken got=%h exp=%h", pc, 32'h3008); bad++; end
    clear_inputs();
    id_valid = 1; id_pc = 32'h3004; id_j = 1; id_idx26 = 26'h0000C10; stall = 1;
    tick();
    total++;
    if (pc !== 32'h3008) begin $display("FAIL j_stall1 got=%h exp=%h", pc, 32'h3008); bad++; end
    tick();
    total++;
    if (pc !== 32'h3008) begin $display("FAIL j_stall2 got=%h exp=%h", pc, 32'h3008); bad++; end
    stall = 0;
    tick();
    total++;
    if (pc !== 32'h3040) begin $display("FAIL j_target got=%h exp=%h", pc, 32'h3040); bad++; end
    clear_inputs();
    $display("test_gtz_stall_j: pc=%h", pc);
  endtask

  task automatic test_jr_exc();
    id_valid = 1; id_pc = 32'h3040; id_jr = 1; id_rs = 32'h3002;
    tick();
    total++;
    if (pc !== 32'h3002) begin $display("FAIL jr_target got=%h exp=%h", pc, 32'h3002); bad++; end
    total++;
    if (if_adel !== 1'b1) begin $display("FAIL jr_adel got=%b exp=1", if_adel); bad++; end
    clear_inputs();
    id_valid = 1; id_j = 1; exc_req = 1; stall = 1;
    #1;
    total++;
    if (if_bd !== 1'b0) begin $display("FAIL exc_bd got=%b exp=0", if_bd); bad++; end
    tick();
    total++;
    if (pc !== 32'h4180) begin $display("FAIL exc_vector got=%h exp=%h", pc, 32'h4180); bad++; end
    clear_inputs();
    $display("test_jr_exc: pc=%h", pc);
  endtask

  task automatic test_simultaneous();
    exc_req = 1; eret_req = 1; epc = 32'h3020;
    tick();
    total++;
    if (pc !== 32'h4180) begin $display("FAIL exc_over_eret got=%h exp=%h", pc, 32'h4180); bad++; end
    exc_req = 0;
    tick();
    total++;
    if (pc !== 32'h3020) begin $display("FAIL eret_target got=%h exp=%h", pc, 32'h3020); bad++; end
    clear_inputs();
    $display("test_simultaneous: pc=%h", pc);
  endtask

  task automatic test_async_reset();
    id_valid = 1; id_pc = 32'h3100; id_br = 1; id_cond = 3'd1; id_rs = 1; id_rt = 2; id_imm16 = 16'h0010;
    #2;
    rst_n = 0;
    #1;
    total++;
    if (pc !== 32'h3000) begin $display("FAIL async_pc got=%h exp=%h", pc, 32'h3000); bad++; end
    total++;
    if (if_bd !== 1'b0) begin $display("FAIL async_bd got=%b exp=0", if_bd); bad++; end
    total++;
    if (if_adel !== 1'b0) begin $display("FAIL async_adel got=%b exp=0", if_adel); bad++; end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    tick();
    total++;
    if (pc !== 32'h3004) begin $display("FAIL async_release got=%h exp=%h", pc, 32'h3004); bad++; end
    $display("test_async_reset: pc=%h", pc);
  endtask

  task automatic test_random();
    bit [31:0] m_pc;
    bit [31:0] picks [6];
    picks[0] = 32'h0; picks[1] = 32'h1; picks[2] = 32'hFFFF_FFFF;
    picks[3] = 32'h8000_0000; picks[4] = 32'h7FFF_FFFF; picks[5] = 32'h0;
    clear_inputs();
    rst_n = 0;
    #3;
    @(negedge clk);
    rst_n = 1;
    #1;
    m_pc = 32'h3000;
    for (int i = 0; i < 300; i++) begin
      picks[5]  = $urandom;
      stall     = ($urandom_range(0, 3) == 0);
      id_valid  = ($urandom_range(0, 4) != 0);
      id_pc     = 32'h3000 + ($urandom_range(0, 1023) << 2);
      id_br     = ($urandom_range(0, 2) == 0);
      id_j      = ($urandom_range(0, 5) == 0);
      id_jr     = ($urandom_range(0, 7) == 0);
      id_cond   = 3'($urandom_range(0, 7));
      id_imm16  = 16'($urandom);
      id_idx26  = 26'($urandom);
      id_rs     = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 5)] : 32'h3000 + 32'($urandom_range(0, 4095));
      id_rt     = ($urandom_range(0, 2) == 0) ? id_rs : picks[$urandom_range(0, 5)];
      exc_req   = ($urandom_range(0, 15) == 0);
      eret_req  = ($urandom_range(0, 11) == 0);
      epc       = 32'h3000 + ($urandom_range(0, 1023) << 2);
      #2;
      total++;
      if (pc !== m_pc) begin $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, pc, m_pc); bad++; end
      total++;
      if (pc_plus_4 !== m_pc + 32'd4) begin $display("FAIL rnd_pc4 cyc=%0d got=%h exp=%h", i, pc_plus_4, m_pc + 32'd4); bad++; end
      total++;
      if (if_bd !== ref_bd()) begin $display("FAIL rnd_bd cyc=%0d got=%b exp=%b", i, if_bd, ref_bd()); bad++; end
      total++;
      if (if_adel !== ref_adel(m_pc)) begin $display("FAIL rnd_adel cyc=%0d got=%b exp=%b", i, if_adel, ref_adel(m_pc)); bad++; end
      m_pc = ref_next(m_pc);
      tick();
    end
    clear_inputs();
    $display("test_random: 300 cycles, final pc=%h", pc);
  endtask

  initial begin
    test_reset();
    test_beq();
    test_gtz_stall_j();
    test_jr_exc();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Fetch-stage PC generator for the pipelined MIPS core: the parametrised successor of the single-cycle next-PC calculator. It owns the PC register and the following behaviour:

- Stall hold, with MIPS delay-slot semantics.
- Branch/jump redirects resolved in ID, with a six-way branch-condition mode.
- Exception entry and ERET return.
- Fetch address-error detection.

It sits between the hazard unit, the ID-stage comparator/decoder, CP0 and the instruction memory.

## Interface
- `WIDTH`, 32: PC/data width.
- `RESET_PC`, 32'h0000_3000: PC after reset.
- `EXC_VECTOR`, 32'h0000_4180: exception entry address.
- `IMEM_BASE`, 32'h0000_3000: lowest legal fetch address.
- `IMEM_BYTES`, 4096: size of the legal fetch window, in bytes.

- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold PC (from hazard unit).
- `id_valid` in 1: ID stage holds a real instruction (not a bubble).
- `id_pc` in WIDTH: PC of the ID-stage instruction.
- `id_br` in 1: ID instruction is a conditional branch.
- `id_cond` in 3: branch condition. Encodings: 0 EQ, 1 NE, 2 LEZ, 3 GTZ, 4 LTZ, 5 GEZ; 6–7 reserved, never taken.
- `id_j` in 1: J/JAL (absolute).
- `id_jr` in 1: JR/JALR (register).
- `id_imm16` in 16: branch offset, in words.
- `id_idx26` in 26: jump index.
- `id_rs` in WIDTH: forwarded rs value.
- `id_rt` in WIDTH: forwarded rt value.
- `exc_req` in 1: exception taken this cycle (from CP0).
- `eret_req` in 1: ERET committing this cycle.
- `epc` in WIDTH: return address for ERET.
- `pc` out WIDTH: current fetch address (registered).
- `pc_plus_4` out WIDTH: `pc + 4`.
- `if_bd` out 1: the instruction at `pc` is a delay slot.
- `if_adel` out 1: fetch address error at `pc`.

## Operation
- **Condition evaluation.** Operands are signed, two's-complement `WIDTH`-bit values.
  - EQ: `rs==rt`.
  - NE: `rs!=rt`.
  - LEZ: `rs<=0`.
  - GTZ: `rs>0`.
  - LTZ: `rs<0`.
  - GEZ: `rs>=0`.
- **Redirect valid.** `cti_taken = id_valid & (id_j | id_jr | (id_br & cond_true))`.
- **Targets.** All sums wrap modulo 2^WIDTH.
  - Branch: `id_pc + 4 + (sext(id_imm16) << 2)`.
  - J: `{id_pc_plus4[WIDTH-1:28], id_idx26, 2'b00}`.
  - JR: `id_rs`, passed unaltered; misalignment is caught by `if_adel` one cycle later.
- **Next-PC priority**, highest first:
  1. `exc_req` → `EXC_VECTOR`.
  2. `eret_req` → `epc`.
  3. `stall` → hold `pc`.
  4. `cti_taken` → target.
  5. Otherwise `pc + 4`.
- **Exception and ERET override stall.** If both `exc_req` and `eret_req` are asserted, `exc_req` wins.
- **Multiple control-transfer flags.** If more than one of `id_j`, `id_jr`, `id_br` is asserted, the selection order is `id_jr` > `id_j` > `id_br`. The decoder never asserts more than one, but the order is fixed for determinism.
- **Delay slot.** `if_bd = id_valid & (id_br | id_j | id_jr)`, combinational, asserted whether or not the branch is taken. It is forced to 0 whenever `exc_req` or `eret_req` is asserted.
- **Address error.** `if_adel = (pc[1:0] != 0) | (pc < IMEM_BASE) | (pc >= IMEM_BASE + IMEM_BYTES)`. It is computed combinationally from the PC register. The PC does not self-redirect; CP0 raises `exc_req`.

## Timing
- **Reset.** While `rst_n` is low, regardless of `clk`: `pc = RESET_PC`, `pc_plus_4 = RESET_PC + 4`, `if_bd = 0`, `if_adel = 0` (given defaults).
- **Reset release.** The first update happens on the first rising edge after `rst_n` goes high.
- **Reset mid-operation.** Asserting reset in the middle of a redirect or stall discards it immediately.
- **Redirect latency.** One cycle. A control transfer in ID at cycle N is fetched at cycle N+1. The delay slot is the instruction at `pc` during cycle N and is never squashed by this block.
- **Stall with control transfer.** Under stall with a taken control transfer, PC holds. The ID instruction remains in ID and redirects on the first non-stalled cycle.
- **Exception/ERET latency.** `exc_req` or `eret_req` at cycle N gives `pc = EXC_VECTOR` or `epc` at N+1. These are single-cycle pulses.
- **No handshake with IMEM.** The fetch address is valid every cycle.

## Structure
- Shared `mips_pkg` holds:
  - `id_cond` encodings: `COND_EQ`…`COND_GEZ`.
  - `RESET_PC`, `EXC_VECTOR`, `IMEM_BASE` defaults.
  - `WIDTH` default.
- One sub-module, `br_cond`: the combinational six-way condition evaluator taking `rs`, `rt` and `id_cond`. The ID-stage bypass checker reuses it.
- The rest of the block is a single PC register plus a priority mux.

## Test plan
- **Reset and sequential fetch.** Reset low, then high. Required: `pc = 0x3000` during reset, then 0x3004, 0x3008 on successive edges; `if_adel = 0`.
- **Taken BEQ.** `id_pc = 0x3010`, `id_br = 1`, EQ, `rs = rt = 5`, `imm16 = 0xFFFC`. Required: next `pc = 0x3004`; `if_bd = 1` during the branch cycle.
- **Untaken GTZ, then stall with J.**
  - GTZ with `rs = 0x8000_0000`. Required: PC increments by 4.
  - J with `idx26 = 0x0000C10` under `stall` for 2 cycles. Required: `pc` holds, then becomes `0x0000_3040`.
- **JR misaligned.** `id_rs = 0x3002`. Required: `pc = 0x3002`, `if_adel = 1`. Then `exc_req` together with `stall`. Required: `pc = 0x4180`, `if_bd = 0`.
- **Simultaneous events.** `exc_req` and `eret_req` with `epc = 0x3020` in the same cycle. Required: `pc = 0x4180`. Then `eret_req` alone. Required: `pc = 0x3020`.
- **Asynchronous reset.** Assert `rst_n = 0` mid-cycle while a taken branch is pending. Required: `pc = 0x3000` immediately, before the next edge, and the branch is not taken after release.
